computer: RTL and testbench

- Complete 8-bit SAP-1.5 style microcomputer as a single top-level block: program counter, MAR, 16x8 RAM, instruction register, A/B registers, ALU, flags, output register and microsequencer.
- Runs a preloaded program after reset and drives its result on out_val.
- Sits at the top of the design; the board wrapper connects the clock, reset and the out_val display.

---
 rtl/computer.sv | 170 +++++++++++++++++
 tb/tb_computer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/computer.sv
// rtl/computer.sv - 8-bit SAP-1.5 style microcomputer with 16x8 RAM and a 6-step microsequencer
module cpu_register (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] d,
    output logic [7:0] latched_data
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            latched_data <= 8'h00;
        end else if (load) begin
            latched_data <= d;
        end
    end
endmodule

module computer #(
    parameter string MEM_INIT_FILE = ""
) (
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] out_val
);
    localparam logic [2:0] T0 = 3'd0;
    localparam logic [2:0] T1 = 3'd1;
    localparam logic [2:0] T2 = 3'd2;
    localparam logic [2:0] T3 = 3'd3;
    localparam logic [2:0] T5 = 3'd5;

    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_LDB = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_STA = 4'h5;
    localparam logic [3:0] OP_LDI = 4'h6;
    localparam logic [3:0] OP_JMP = 4'h7;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    // RAM image is fixed at initialisation only; reset never touches it.
    function automatic logic [15:0][7:0] init_image();
        logic [7:0]        img [16];
        logic [15:0][7:0]  flat;
        img = '{8'h1E, 8'h2F, 8'h30, 8'hE0, 8'hF0, 8'h00, 8'h00, 8'h00,
                8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h44, 8'h22};
        for (int i = 0; i < 16; i++) begin
            flat[i] = img[i];
        end
        return flat;
    endfunction

    logic [15:0][7:0] ram = init_image();

    logic [2:0] step;
    logic [3:0] pc;
    logic [3:0] mar;
    logic [7:0] ir;
    logic       carry;
    logic       zero;
    logic       halted;

    logic [7:0] a_val;
    logic [7:0] b_val;
    logic [7:0] a_next;
    logic       a_load;
    logic       b_load;

    logic [3:0] opcode;
    logic [3:0] operand;
    logic [7:0] ram_q;
    logic [8:0] sum;
    logic [8:0] diff;

    assign opcode  = ir[7:4];
    assign operand = ir[3:0];
    assign ram_q   = ram[mar];
    assign sum     = {1'b0, a_val} + {1'b0, b_val};
    assign diff    = {1'b0, a_val} - {1'b0, b_val};

    always_comb begin
        a_load = 1'b0;
        b_load = 1'b0;
        a_next = ram_q;
        if (!halted) begin
            if (step == T2 && opcode == OP_LDI) begin
                a_load = 1'b1;
                a_next = {4'h0, operand};
            end else if (step == T3) begin
                case (opcode)
                    OP_LDA: a_load = 1'b1;
                    OP_LDB: b_load = 1'b1;
                    OP_ADD: begin
                        a_load = 1'b1;
                        a_next = sum[7:0];
                    end
                    OP_SUB: begin
                        a_load = 1'b1;
                        a_next = diff[7:0];
                    end
                    default: ;
                endcase
            end
        end
    end

    cpu_register u_register_A (
        .clk          (clk),
        .rst_n        (reset),
        .load         (a_load),
        .d            (a_next),
        .latched_data (a_val)
    );

    cpu_register u_register_B (
        .clk          (clk),
        .rst_n        (reset),
        .load         (b_load),
        .d            (ram_q),
        .latched_data (b_val)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            step    <= T0;
            pc      <= 4'h0;
            mar     <= 4'h0;
            ir      <= 8'h00;
            out_val <= 8'h00;
            carry   <= 1'b0;
            zero    <= 1'b0;
            halted  <= 1'b0;
        end else if (!halted) begin
            step <= (step == T5) ? T0 : step + 3'd1;
            case (step)
                T0: mar <= pc;
                T1: begin
                    ir <= ram_q;
                    pc <= pc + 4'd1;
                end
                T2: begin
                    case (opcode)
                        OP_LDA, OP_LDB, OP_STA: mar <= operand;
                        OP_JMP: pc      <= operand;
                        OP_OUT: out_val <= a_val;
                        OP_HLT: halted  <= 1'b1;
                        default: ;
                    endcase
                end
                T3: begin
                    // Carry on SUB means "no borrow", i.e. A >= B.
                    if (opcode == OP_ADD) begin
                        carry <= sum[8];
                        zero  <= (sum[7:0] == 8'h00);
                    end else if (opcode == OP_SUB) begin
                        carry <= ~diff[8];
                        zero  <= (diff[7:0] == 8'h00);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!halted && step == T3 && opcode == OP_STA) begin
            ram[mar] <= a_val;
        end
    end
endmodule

// File: tb/tb_computer.sv
// tb/tb_computer.sv - randomized and directed checks of computer against an instruction-level model
module tb_computer;
    logic       clk;
    logic       reset;
    logic [7:0] out_val;

    int n_checks;
    int n_fails;

    logic [7:0] prog [16];
    int m_ram [16];
    int m_a, m_b, m_pc, m_out, m_c, m_z, m_halt;
    int snap_a, snap_b, snap_out, snap_pc;

    computer dut (
        .clk     (clk),
        .reset   (reset),
        .out_val (out_val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reset held for 2 cycles; released on a falling edge so the next rising edge is edge 1.
    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic model_reset();
        m_a = 0; m_b = 0; m_pc = 0; m_out = 0; m_c = 0; m_z = 0; m_halt = 0;
    endtask

    task automatic load_prog();
        for (int i = 0; i < 16; i++) begin
            dut.ram[i] <= prog[i];
            m_ram[i] = prog[i];
        end
    endtask

    task automatic model_step();
        int op, arg, r;
        if (m_halt != 0) return;
        op   = m_ram[m_pc] / 16;
        arg  = m_ram[m_pc] % 16;
        m_pc = (m_pc + 1) % 16;
        case (op)
            1: m_a = m_ram[arg];
            2: m_b = m_ram[arg];
            3: begin
                r   = m_a + m_b;
                m_c = (r > 255) ? 1 : 0;
                m_a = r % 256;
                m_z = (m_a == 0) ? 1 : 0;
            end
            4: begin
                m_c = (m_a >= m_b) ? 1 : 0;
                m_a = (m_a - m_b + 256) % 256;
                m_z = (m_a == 0) ? 1 : 0;
            end
            5: m_ram[arg] = m_a;
            6: m_a = arg;
            7: m_pc = arg;
            14: m_out = m_a;
            15: m_halt = 1;
            default: ;
        endcase
    endtask

    task automatic compare_state(input string tag);
        check({tag, ".A"}, dut.u_register_A.latched_data, m_a);
        check({tag, ".B"}, dut.u_register_B.latched_data, m_b);
        check({tag, ".out"}, out_val, m_out);
        check({tag, ".pc"}, dut.pc, m_pc);
        check({tag, ".halted"}, dut.halted, m_halt);
        check({tag, ".carry"}, dut.carry, m_c);
        check({tag, ".zero"}, dut.zero, m_z);
    endtask

    task automatic run_program(input string tag, input int n_instr);
        apply_reset();
        model_reset();
        for (int k = 0; k < n_instr; k++) begin
            tick(6);
            model_step();
            compare_state($sformatf("%s.i%0d", tag, k));
        end
        for (int i = 0; i < 16; i++) begin
            check($sformatf("%s.ram%0d", tag, i), dut.ram[i], m_ram[i]);
        end
    endtask

    task automatic set_prog(input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2,
                            input logic [7:0] p3, input logic [7:0] p4,
                            input logic [7:0] d14, input logic [7:0] d15);
        for (int i = 0; i < 16; i++) prog[i] = 8'h00;
        prog[0] = p0; prog[1] = p1; prog[2] = p2; prog[3] = p3; prog[4] = p4;
        prog[14] = d14; prog[15] = d15;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        reset    = 1'b0;

        // Built-in default program with its fixed timeline.
        apply_reset();
        #1;
        check("rst.A", dut.u_register_A.latched_data, 0);
        check("rst.B", dut.u_register_B.latched_data, 0);
        check("rst.out", out_val, 0);
        check("rst.pc", dut.pc, 0);
        check("rst.halted", dut.halted, 0);
        tick(3);  check("dflt.e3.A", dut.u_register_A.latched_data, 8'h00);
        tick(1);  check("dflt.e4.A", dut.u_register_A.latched_data, 8'h44);
        tick(6);  check("dflt.e10.B", dut.u_register_B.latched_data, 8'h22);
        tick(2);  check("dflt.e12.A", dut.u_register_A.latched_data, 8'h44);
        tick(4);  check("dflt.e16.A", dut.u_register_A.latched_data, 8'h66);
        check("dflt.e16.carry", dut.carry, 0);
        check("dflt.e16.zero", dut.zero, 0);
        tick(4);  check("dflt.e20.out", out_val, 8'h00);
        tick(1);  check("dflt.e21.out", out_val, 8'h66);
        tick(3);  check("dflt.e24.B", dut.u_register_B.latched_data, 8'h22);
        tick(2);  check("dflt.e26.halted", dut.halted, 0);
        tick(1);  check("dflt.e27.halted", dut.halted, 1);
        check("dflt.e27.pc", dut.pc, 5);
        snap_a = dut.u_register_A.latched_data; snap_b = dut.u_register_B.latched_data;
        snap_out = out_val; snap_pc = dut.pc;
        tick(20);
        check("freeze.A", dut.u_register_A.latched_data, 8'h66);
        check("freeze.B", dut.u_register_B.latched_data, 8'h22);
        check("freeze.out", out_val, 8'h66);
        check("freeze.pc", dut.pc, 5);
        check("freeze.halted", dut.halted, 1);
        check("freeze.same", (dut.u_register_A.latched_data == snap_a && out_val == snap_out &&
              dut.u_register_B.latched_data == snap_b && dut.pc == snap_pc) ? 1 : 0, 1);

        // Mid-run reset aborts immediately and the program reruns with the same timing.
        apply_reset();
        tick(14);
        reset = 1'b0;
        #1;
        check("midrst.A", dut.u_register_A.latched_data, 0);
        check("midrst.B", dut.u_register_B.latched_data, 0);
        check("midrst.out", out_val, 0);
        check("midrst.pc", dut.pc, 0);
        check("midrst.ir", dut.ir, 0);
        @(negedge clk);
        reset = 1'b1;
        tick(3);  check("rerun.e3.A", dut.u_register_A.latched_data, 8'h00);
        tick(1);  check("rerun.e4.A", dut.u_register_A.latched_data, 8'h44);
        tick(17); check("rerun.e21.out", out_val, 8'h66);

        // SUB with borrow.
        set_prog(8'h1E, 8'h2F, 8'h40, 8'hE0, 8'hF0, 8'h22, 8'h44);
        reset = 1'b0; load_prog();
        run_program("sub", 6);
        check("sub.out", out_val, 8'hDE);
        check("sub.carry", dut.carry, 0);
        check("sub.zero", dut.zero, 0);

        // ADD overflow.
        set_prog(8'h1E, 8'h2F, 8'h30, 8'hE0, 8'hF0, 8'hFF, 8'h01);
        reset = 1'b0; load_prog();
        run_program("ovf", 6);
        check("ovf.A", dut.u_register_A.latched_data, 8'h00);
        check("ovf.carry", dut.carry, 1);
        check("ovf.zero", dut.zero, 1);

        // LDI / STA / LDA / OUT / JMP loop.
        set_prog(8'h65, 8'h5D, 8'h1D, 8'hE0, 8'h70, 8'h00, 8'h00);
        reset = 1'b0; load_prog();
        run_program("loop", 12);
        check("loop.out", out_val, 8'h05);
        check("loop.ram13", dut.ram[13], 8'h05);
        check("loop.halted", dut.halted, 0);

        // Undefined opcode behaves as NOP.
        set_prog(8'h90, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        reset = 1'b0; load_prog();
        run_program("undef", 4);
        check("undef.pc", dut.pc, 2);
        check("undef.halted", dut.halted, 1);
        check("undef.A", dut.u_register_A.latched_data, 0);
        check("undef.out", out_val, 0);

        // Random programs.
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 16; i++) prog[i] = 8'($urandom);
            reset = 1'b0; load_prog();
            run_program($sformatf("rnd%0d", r), 14);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
